// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width, counter sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam int DATA_BITS = 8;

  // One encoding shared by both engines; the transmitter never enters WAIT_IDLE.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_state_t;

  // Width of a counter that must hold the values 0 .. clks-1.
  function automatic int cnt_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: ticks once every CLKS_PER_BIT clocks while running.
// Latency: first tick CLKS_PER_BIT clocks after clear drops; after load_half the first tick is shortened.
// Backpressure: none; clear holds the counter at its full-period value.
//
// Ports:
//   clock, reset  system clock, synchronous active-low reset
//   clear         hold counter at full period (engine idle)
//   load_half     load the shortened start-bit interval (overrides clear)
//   tick          high for one clock when the counter reaches zero
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 9
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic load_half,
  output logic tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  // The receiver only sees the start edge two synchroniser stages late, so the
  // half-bit wait is shortened by those two clocks; the sample then lands
  // CLKS_PER_BIT/2 clocks after the raw line edge.
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= FULL;
    end else if (load_half) begin
      cnt <= HALF;
    end else if (clear || cnt == '0) begin
      // Reload on the tick so every later bit lasts exactly CLKS_PER_BIT clocks.
      cnt <= FULL;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_transceiver.sv
// 8N1 UART with independent receive and transmit engines (full duplex).
// Latency: rx_data updates at the bit-7 sample; rx_byte_ready/tx start one clock after the deciding edge.
// Backpressure: start_transmit ignored while tx_busy; no queueing, received bytes are never stalled.
//
// Ports:
//   clock, reset                   system clock, synchronous active-low reset
//   rx                             serial input (asynchronous, idle high)
//   rx_data                        last received byte (LSB first on the wire)
//   rx_byte_ready, rx_frame_error  one-clock pulses at the mid-stop-bit sample
//   data, start_transmit           byte to send and its request strobe
//   tx, tx_busy                    serial output (idle high) and transmit-in-progress flag
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_byte_ready,
  output logic                 rx_frame_error,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 start_transmit,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  // ---------------- receiver ----------------
  logic                 rx_meta;
  logic                 rx_s;
  uart_state_t          rx_state;
  logic [2:0]           rx_idx;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_tick;
  logic                 rx_clear;
  logic                 rx_load_half;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  assign rx_load_half = (rx_state == IDLE) && !rx_s;
  assign rx_clear     = (rx_state == IDLE) || (rx_state == WAIT_IDLE);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clock     (clock),
    .reset     (reset),
    .clear     (rx_clear),
    .load_half (rx_load_half),
    .tick      (rx_tick)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_state       <= IDLE;
      rx_idx         <= '0;
      rx_shift       <= '0;
      rx_data        <= '0;
      rx_byte_ready  <= 1'b0;
      rx_frame_error <= 1'b0;
    end else begin
      rx_byte_ready  <= 1'b0;
      rx_frame_error <= 1'b0;
      case (rx_state)
        IDLE: begin
          if (!rx_s) rx_state <= START;
        end
        START: begin
          // A line that is high again at mid start bit was a glitch.
          if (rx_tick) begin
            if (rx_s) begin
              rx_state <= IDLE;
            end else begin
              rx_state <= DATA;
              rx_idx   <= '0;
            end
          end
        end
        DATA: begin
          if (rx_tick) begin
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            rx_idx   <= rx_idx + 3'd1;
            if (rx_idx == LAST_BIT) begin
              // Publish the byte now so it is visible before the stop bit.
              rx_data  <= {rx_s, rx_shift[DATA_BITS-1:1]};
              rx_state <= STOP;
            end
          end
        end
        STOP: begin
          if (rx_tick) begin
            if (rx_s) begin
              rx_byte_ready <= 1'b1;
              rx_state      <= IDLE;
            end else begin
              rx_frame_error <= 1'b1;
              rx_state       <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          // A low stop bit may be a break; do not treat it as a new start bit.
          if (rx_s) rx_state <= IDLE;
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  uart_state_t          tx_state;
  logic [2:0]           tx_idx;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_tick;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clock     (clock),
    .reset     (reset),
    .clear     (tx_state == IDLE),
    .load_half (1'b0),
    .tick      (tx_tick)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_state <= IDLE;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      case (tx_state)
        IDLE: begin
          // tx_busy is always low here, so requests during a frame are dropped.
          if (start_transmit) begin
            tx_shift <= data;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            tx_state <= START;
          end
        end
        START: begin
          if (tx_tick) begin
            tx       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
            tx_idx   <= '0;
            tx_state <= DATA;
          end
        end
        DATA: begin
          if (tx_tick) begin
            if (tx_idx == LAST_BIT) begin
              tx       <= 1'b1;
              tx_state <= STOP;
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
              tx_idx   <= tx_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (tx_tick) begin
            tx_busy  <= 1'b0;
            tx_state <= IDLE;
          end
        end
        default: begin
          tx       <= 1'b1;
          tx_busy  <= 1'b0;
          tx_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// Self-checking bench for uart_transceiver: random bytes on rx at 8.7 clocks/bit,
// echoed through rx_byte_ready -> start_transmit, tx decoded against frame arithmetic.
// Time unit: 1000 units per 1 MHz clock period.
module tb_uart_transceiver;

  localparam int CPB    = 9;
  localparam int CLK_HP = 500;
  localparam int RX_BIT = 8700;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_byte_ready;
  logic       rx_frame_error;
  logic [7:0] data;
  logic       start_transmit;
  logic       tx;
  logic       tx_busy;

  logic       loop_en;
  logic       man_start;
  logic [7:0] man_data;

  int n_checks = 0;
  int n_errors = 0;
  int rdy_cnt  = 0;
  int fe_cnt   = 0;
  logic [7:0] last_rdy = 8'h00;

  assign start_transmit = loop_en ? rx_byte_ready : man_start;
  assign data           = loop_en ? rx_data : man_data;

  uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
    .clock          (clock),
    .reset          (reset),
    .rx             (rx),
    .rx_data        (rx_data),
    .rx_byte_ready  (rx_byte_ready),
    .rx_frame_error (rx_frame_error),
    .data           (data),
    .start_transmit (start_transmit),
    .tx             (tx),
    .tx_busy        (tx_busy)
  );

  always #(CLK_HP) clock = ~clock;

  // Event counters for the receive-side strobes.
  always @(negedge clock) begin
    if (rx_byte_ready === 1'b1) begin
      rdy_cnt++;
      last_rdy = rx_data;
    end
    if (rx_frame_error === 1'b1) fe_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one frame on rx at 8.7 clocks/bit with a random phase that never lands on a clock edge.
  task automatic drive_rx(input logic [7:0] b, input logic stop_val);
    int r0;
    int f0;
    r0 = rdy_cnt;
    f0 = fe_cnt;
    @(posedge clock);
    #(100 * $urandom_range(0, 8) + $urandom_range(10, 90));
    rx = 1'b0;
    #(RX_BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(RX_BIT);
    end
    chk("rx_data_before_stop", rx_data, b);
    chk("rdy_before_stop", rdy_cnt - r0, 0);
    rx = stop_val;
    #(RX_BIT);
    rx = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    if (stop_val) begin
      chk("rdy_pulses", rdy_cnt - r0, 1);
      chk("fe_pulses", fe_cnt - f0, 0);
      chk("rdy_byte", last_rdy, b);
    end else begin
      chk("fe_pulses", fe_cnt - f0, 1);
      chk("rdy_pulses", rdy_cnt - r0, 0);
      chk("rx_data_kept", rx_data, b);
    end
  endtask

  // Wait for a start bit, then compare 90 clocks of tx against the ideal 8N1 waveform.
  task automatic check_tx_frame(input logic [7:0] b);
    int   waited;
    int   busy_cnt;
    int   mism;
    logic lvl [90];
    logic [9:0] frame;
    logic [7:0] dec;
    frame = {1'b1, b, 1'b0};
    waited = 0;
    busy_cnt = 0;
    @(negedge clock);
    while (tx !== 1'b0 && waited < 300) begin
      @(negedge clock);
      waited++;
    end
    if (tx !== 1'b0) begin
      chk("tx_start_timeout", tx, 0);
      return;
    end
    for (int c = 0; c < 90; c++) begin
      lvl[c] = tx;
      if (tx_busy === 1'b1) busy_cnt++;
      @(negedge clock);
    end
    chk("tx_busy_after_stop", tx_busy, 0);
    chk("tx_busy_len", busy_cnt, 90);
    dec = 8'h00;
    for (int i = 0; i < 10; i++) begin
      mism = 0;
      for (int k = 0; k < CPB; k++) if (lvl[i*CPB+k] !== frame[i]) mism++;
      chk($sformatf("tx_bit%0d", i), mism, 0);
      if (i >= 1 && i <= 8) dec[i-1] = lvl[i*CPB+4];
    end
    chk("tx_decoded", dec, b);
  endtask

  task automatic send_echo(input logic [7:0] b);
    fork
      drive_rx(b, 1'b1);
      check_tx_frame(b);
    join
  endtask

  initial begin
    #(20_000_000);
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] d0;
    logic [7:0] x;
    int r0;
    int f0;
    int lows;
    reset     = 1'b0;
    rx        = 1'b1;
    loop_en   = 1'b1;
    man_start = 1'b0;
    man_data  = 8'h00;

    // Reset state.
    @(posedge clock);
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_busy", tx_busy, 0);
    chk("reset_rdy", rx_byte_ready, 0);
    chk("reset_fe", rx_frame_error, 0);
    chk("reset_rx_data", rx_data, 8'h00);
    @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);

    // Known byte through receiver and echo.
    send_echo(8'h6A);

    // Random bytes with random line phase.
    for (int n = 0; n < 6; n++) send_echo(8'($urandom));

    // Short low glitch must not start a frame.
    r0 = rdy_cnt;
    f0 = fe_cnt;
    d0 = rx_data;
    @(posedge clock);
    #300;
    rx = 1'b0;
    #3000;
    rx = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    chk("glitch_rdy", rdy_cnt - r0, 0);
    chk("glitch_fe", fe_cnt - f0, 0);
    chk("glitch_rx_data", rx_data, d0);
    chk("glitch_no_echo", tx_busy, 0);

    // Low stop bit, then a good frame.
    drive_rx(8'hA5, 1'b0);
    repeat (10) @(negedge clock);
    chk("fe_no_echo", tx_busy, 0);
    send_echo(8'h3C);

    // Direct transmit: mid-frame request ignored, data change after acceptance ignored.
    loop_en = 1'b0;
    x = 8'($urandom);
    fork
      check_tx_frame(x);
      begin
        @(negedge clock);
        man_data  = x;
        man_start = 1'b1;
        @(negedge clock);
        man_start = 1'b0;
        man_data  = ~x;
        repeat (40) @(negedge clock);
        man_data  = 8'h12;
        man_start = 1'b1;
        @(negedge clock);
        man_start = 1'b0;
      end
    join
    lows = 0;
    for (int c = 0; c < 30; c++) begin
      if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
      @(negedge clock);
    end
    chk("no_queued_frame", lows, 0);

    fork
      check_tx_frame(8'hFF);
      begin
        @(negedge clock);
        man_data  = 8'hFF;
        man_start = 1'b1;
        @(negedge clock);
        man_start = 1'b0;
      end
    join

    // Reset in the middle of a transmit frame.
    @(negedge clock);
    man_data  = 8'h00;
    man_start = 1'b1;
    @(negedge clock);
    man_start = 1'b0;
    repeat (30) @(negedge clock);
    chk("midframe_busy", tx_busy, 1);
    chk("midframe_tx_low", tx, 0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("midreset_tx", tx, 1);
    chk("midreset_busy", tx_busy, 0);
    chk("midreset_rx_data", rx_data, 8'h00);
    @(negedge clock);
    reset = 1'b1;
    lows = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (tx !== 1'b1) lows++;
    end
    chk("post_reset_idle", lows, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
